mul_div: RTL
============

MUL_DIV -- requirements
Module: mul_div

Interface
REQ-001 XLEN, 32: operand and result width; only 32 is supported.
REQ-002 clk  in  1: single clock; all state updates on the rising edge.
REQ-003 rst  in  1: reset, synchronous, active-high.
REQ-004 flush  in  1: abort any in-flight operation.
REQ-005 valid_in  in  1: request strobe; instr, a_in and b_in are valid.
REQ-006 ready  out  1: unit can accept a request this cycle.
REQ-007 instr  in  32 (instr_t): RV32M R-type instruction.
REQ-008 a_in  in  32 (data_t): rs1 operand.
REQ-009 b_in  in  32 (data_t): rs2 operand.
REQ-010 valid_out  out  1: one-cycle pulse; c_out holds the result.
REQ-011 c_out  out  32 (data_t): result.
REQ-012 rd_wr  out  1: register-write enable; equals valid_out.

Function
REQ-013 Request decode: opcode 0110011 with funct7 0000001. funct3 selects MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
REQ-014 Acceptance occurs on any cycle where valid_in=1 and ready=1 and decode matches. The unit captures instr, a_in and b_in in that cycle. A non-M instr is ignored, and the state stays unchanged.
REQ-015 States: IDLE, CALC, FIX, DONE. ready=1 only in IDLE.
REQ-016 IDLE -> CALC on acceptance of a normal operation. IDLE -> DONE on acceptance of a special-case division (REQ-021, REQ-022).
REQ-017 CALC performs exactly 32 iterations, one per cycle, counted by a 5-bit counter.
- Multiply: shift-add on operand magnitudes into a 64-bit product.
- Divide: restoring divide on magnitudes, giving quotient and remainder.
- CALC -> FIX after iteration 32.
REQ-018 FIX applies sign correction and selects the result, then moves to DONE.
- Multiply: negate the product if exactly one operand is treated as signed and negative. MULH treats both as signed, MULHSU treats rs1 only, MUL/MULHU are unsigned for the low half.
- Divide: quotient is negative iff the operand signs differ (signed ops only). Remainder takes the sign of the dividend.
REQ-019 Result selection:
- MUL = product[31:0].
- MULH/MULHSU/MULHU = product[63:32].
- DIV/DIVU = quotient.
- REM/REMU = remainder.
REQ-020 DONE lasts one cycle. valid_out=1 and rd_wr=1 in that cycle, then the unit returns to IDLE. There is no output backpressure.
REQ-021 Divide by zero (b_in=0): the quotient is 0xFFFFFFFF for DIV/DIVU and the remainder is a_in for REM/REMU. The result appears with zero iterations.
REQ-022 Signed overflow (DIV/REM with a_in=0x80000000 and b_in=0xFFFFFFFF): DIV gives 0x80000000 and REM gives 0. The result appears with zero iterations.
REQ-023 Latency, counted from the accept edge:
- Normal operation: valid_out is asserted in the 34th cycle after acceptance (32 CALC + 1 FIX + 1 DONE).
- Special case: valid_out is asserted in the next cycle.
REQ-024 c_out updates only on entry to DONE and holds its value until the next DONE.
REQ-025 Changes on instr, a_in or b_in after acceptance have no effect on the in-flight operation.
REQ-026 flush=1 forces IDLE on the next edge, with no valid_out for the aborted operation.
- flush has priority over acceptance in the same cycle, so nothing is accepted.
- flush during DONE does not suppress the valid_out pulse already present in that cycle.
REQ-027 Back-to-back operation: a new request can be accepted in the cycle after DONE, because IDLE has ready=1.

Reset
REQ-028 While rst=1 on a clock edge: state=IDLE, counter=0, ready=1, valid_out=0, rd_wr=0, c_out=0x00000000.
REQ-029 rst has priority over flush and valid_in.
REQ-030 rst asserted mid-operation discards the operation, and no valid_out follows.

Verification
REQ-031 MUL (instr 0x02208033), a=0x00001234, b=0x00005678 -> c_out=0x06260060, with valid_out exactly 34 cycles after acceptance.
REQ-032 MULH (0x02209033), a=b=0x80000000 -> 0x40000000. MULHU (0x0220B033), a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU (0x0220A033), a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF.
REQ-033 DIV (0x0220C033), 7 / 0xFFFFFFFE -> 0xFFFFFFFD. REM (0x0220E033), same operands -> 0x00000001. DIVU (0x0220D033), 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF.
REQ-034 DIVU, 5/0 -> 0xFFFFFFFF. REMU (0x0220F033), 5/0 -> 0x00000005. DIV, 0x80000000 / 0xFFFFFFFF -> 0x80000000. All three with valid_out 1 cycle after acceptance.
REQ-035 Start DIV, assert flush in CALC cycle 10 -> IDLE next edge, no valid_out, ready=1. Then accept MUL 3*4 -> 0x0000000C.
REQ-036 Random regression, 10000 operations per funct3, checked against a 64-bit reference model. Also assert rst mid-CALC -> all outputs at reset values and no valid_out.

Source files
------------

// File: rtl/mul_div.sv
`default_nettype none
// ============================================================================
// Module      : mul_div
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide on operand magnitudes, 32 iterations, then a
//               sign-fix cycle and a one-cycle result pulse. Divide-by-zero
//               and signed overflow bypass the iterations entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            valid_in,
    output logic            ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            valid_out,
    output logic [XLEN-1:0] c_out,
    output logic            rd_wr
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_FUNCT7_MD  = 7'b0000001;
    localparam logic [2:0] C_F3_MUL     = 3'b000;
    localparam logic [2:0] C_F3_MULH    = 3'b001;
    localparam logic [2:0] C_F3_MULHSU  = 3'b010;
    localparam logic [XLEN-1:0] C_ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] C_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;        // captured funct3
    logic                a_neg_q, a_neg_d;  // rs1 treated signed and negative
    logic                b_neg_q, b_neg_d;  // rs2 treated signed and negative
    logic [XLEN-1:0]     opb_q, opb_d;      // multiplicand / divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;      // mul: {hi, multiplier}; div: {rem, quot}
    logic [XLEN-1:0]     c_out_q, c_out_d;

    // ------------------------------------------------------------------
    // Request-side decode signals
    // ------------------------------------------------------------------
    logic [2:0]      w_in_f3;
    logic            w_in_is_m;
    logic            w_in_div;
    logic            w_in_a_signed;
    logic            w_in_b_signed;
    logic            w_in_a_neg;
    logic            w_in_b_neg;
    logic [XLEN-1:0] w_in_a_mag;
    logic [XLEN-1:0] w_in_b_mag;
    logic            w_in_div_zero;
    logic            w_in_overflow;
    logic [XLEN-1:0] w_in_special_res;
    logic            w_accept;

    // Only opcode, funct3 and funct7 matter; register indices are the
    // register file's business.
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr[24:15], instr[11:7]};

    // Decode the incoming request and prepare operand magnitudes/special results
    always_comb begin
        w_in_f3          = instr[14:12];
        w_in_is_m        = (instr[6:0] == C_OPC_OP) && (instr[31:25] == C_FUNCT7_MD);
        w_in_div         = w_in_f3[2];
        w_in_a_signed    = 1'b0;
        w_in_b_signed    = 1'b0;
        if (w_in_div) begin
            // DIV/REM are signed (funct3[0]=0), DIVU/REMU unsigned
            w_in_a_signed = ~w_in_f3[0];
            w_in_b_signed = ~w_in_f3[0];
        end else begin
            w_in_a_signed = (w_in_f3 == C_F3_MULH) || (w_in_f3 == C_F3_MULHSU);
            w_in_b_signed = (w_in_f3 == C_F3_MULH);
        end
        w_in_a_neg       = w_in_a_signed & a_in[XLEN-1];
        w_in_b_neg       = w_in_b_signed & b_in[XLEN-1];
        w_in_a_mag       = w_in_a_neg ? (~a_in + 1'b1) : a_in;
        w_in_b_mag       = w_in_b_neg ? (~b_in + 1'b1) : b_in;
        w_in_div_zero    = w_in_div && (b_in == '0);
        w_in_overflow    = w_in_div && !w_in_f3[0] &&
                           (a_in == C_MIN_NEG) && (b_in == C_ALL_ONES);
        w_in_special_res = '0;
        if (w_in_f3[1]) begin
            // REM/REMU: dividend on divide-by-zero, zero on overflow
            w_in_special_res = w_in_div_zero ? a_in : '0;
        end else begin
            // DIV/DIVU: all-ones on divide-by-zero, most-negative on overflow
            w_in_special_res = w_in_div_zero ? C_ALL_ONES : C_MIN_NEG;
        end
        w_accept = valid_in && (state_q == S_IDLE) && w_in_is_m && !flush;
    end

    // ------------------------------------------------------------------
    // Iteration step datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_part;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        // Multiply: add multiplicand to the high half when the multiplier LSB
        // is set, then shift the whole accumulator right by one.
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};
        // Divide: shift the next dividend bit into the partial remainder, try
        // to subtract the divisor and keep the difference if non-negative.
        w_div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        w_div_diff = w_div_part - {1'b0, opb_q};
        if (w_div_diff[XLEN]) begin
            w_div_next = {w_div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            w_div_next = {w_div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_result;

    // Apply operand signs to the magnitude results and pick the output word
    always_comb begin
        w_prod_fix = (a_neg_q ^ b_neg_q) ? (~acc_q + 1'b1) : acc_q;
        w_quot_fix = (a_neg_q ^ b_neg_q) ? (~acc_q[XLEN-1:0] + 1'b1)
                                         : acc_q[XLEN-1:0];
        // Remainder follows the sign of the dividend
        w_rem_fix  = a_neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1)
                             : acc_q[2*XLEN-1:XLEN];
        w_result   = '0;
        if (op_q[2]) begin
            w_result = op_q[1] ? w_rem_fix : w_quot_fix;
        end else if (op_q == C_F3_MUL) begin
            w_result = w_prod_fix[XLEN-1:0];
        end else begin
            w_result = w_prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Next-state and register-load logic
    // ------------------------------------------------------------------
    // FSM sequencing plus datapath loads; flush overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        c_out_d = c_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d    = w_in_f3;
                    a_neg_d = w_in_a_neg;
                    b_neg_d = w_in_b_neg;
                    opb_d   = w_in_b_mag;
                    acc_d   = {{XLEN{1'b0}}, w_in_a_mag};
                    cnt_d   = '0;
                    if (w_in_div_zero || w_in_overflow) begin
                        c_out_d = w_in_special_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? w_div_next : w_mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                c_out_d = w_result;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            c_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            c_out_q <= c_out_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign valid_out = (state_q == S_DONE);
    assign rd_wr     = valid_out;
    assign c_out     = c_out_q;

endmodule
`default_nettype wire
